ripple_updown_counter: RTL and testbench
========================================

Name: ripple_updown_counter

Overview:
- Parameterisable binary ripple counter; counts up or down, selected by `C`.
- Built as a chain of toggle flip-flops. Stage 0 is clocked by `clk`; each later stage is clocked by the previous stage's output.
- Used as a small event/divider counter where ripple settling delay is acceptable.
- Default instance is 4-bit, the drop-in for RippleCounter_4bit users.

Parameters:
- WIDTH, 4, number of counter stages / bits of `Q` (legal range 2..16).

Ports:
- clk  input  1  clock; stage 0 toggles on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); clears all stages immediately.
- T  input  1  toggle enable, shared by all stages; 1 = count, 0 = hold.
- C  input  1  direction; 1 = count up, 0 = count down.
- Q  output  WIDTH  counter value, Q[0] = LSB.
- tc  output  1  terminal count; present only with RIPPLE_TC_EN.

Behaviour:
- Reset:
  - While reset=0, all stages are 0, so Q=0 (and tc per the feature rules), regardless of clk, T or C.
  - Assertion is asynchronous and takes effect without a clock edge.
  - Release must occur away from a clk rising edge. The first count happens on the first clk rising edge after release.
- Stage 0:
  - On each clk rising edge with T=1, Q[0] toggles.
  - With T=0, Q[0] holds.
- Stage i, for i ≥ 1:
  - Positive-edge T flip-flop with the same T, async-cleared by reset.
  - Its clock is Q[i-1] XOR C:
    - Up (C=1): clock is ~Q[i-1], so stage i toggles when Q[i-1] falls 1→0.
    - Down (C=0): clock is Q[i-1], so stage i toggles when Q[i-1] rises 0→1.
- Net result per clk rising edge with T=1:
  - Up: Q ← (Q+1) mod 2^WIDTH.
  - Down: Q ← (Q−1) mod 2^WIDTH.
  - Wrap-around: up 2^WIDTH−1 → 0; down 0 → 2^WIDTH−1.
- Latency / settling:
  - Q[i] settles i stage delays after the clk edge.
  - Intermediate values (ripple glitches) are legal on Q.
  - Q must be fully settled before the next clk rising edge. Consumers sample Q only then.
- Direction change:
  - C may change only while reset=0, or while T=0 and no clk edge is in flight.
  - Toggling C flips every internal stage clock and may cause spurious toggles. This is a protocol violation; the design does not guard against it.
  - The team usage pattern is: assert reset, set C, release reset.
- T changes must meet setup/hold to clk like any synchronous input.
- No synchronous load, no enable gating beyond T.

Optional Feature:
- Macro: RIPPLE_TC_EN.
- Defined:
  - Adds output `tc`.
  - Up mode: tc=1 when Q == all ones.
  - Down mode: tc=1 when Q == all zeros, excluding the reset state. tc is forced 0 while reset=0, and for down mode also until the first count after reset release.
  - tc is combinational from Q and C, so it inherits Q's glitches.
- Undefined: no `tc` port and no tc logic; behaviour of `Q` is identical.

Decomposition:
- Shared package ripple_counter_pkg:
  - constant DIR_UP = 1'b1, DIR_DOWN = 1'b0;
  - default width constant RIPPLE_DEFAULT_WIDTH = 4.
- One sub-module, t_flip_flop: ports clk, reset (async active-low), T, q.
- Top generates WIDTH instances and the per-stage XOR clock muxing.

Test Plan:
- Reset: reset=0 with T=1, C=1, clk running → Q=0 immediately and held; release away from an edge → first rising edge gives Q=1.
- Up count: T=1, C=1, 16 clk edges after release → Q = 1,2,…,15,0; 17th edge → 1.
- Down count: reset, C=0, T=1, release → first edge Q=15, then 14,13,…; 16th edge → 0.
- Hold: counting up to Q=5, set T=0 for 4 edges → Q stays 5; T=1 → next edge Q=6.
- Async reset mid-count: at Q=9 assert reset between edges → Q=0 without waiting for clk; release → counts from 0.
- WIDTH=3 with RIPPLE_TC_EN:
  - Up: Q wraps 7 → 0; tc=1 only while Q=7.
  - Down after first edge: Q=7,6,…,0; tc=1 only at Q=0.

Source files
------------

// File: rtl/ripple_counter_pkg.sv
// Shared constants for the ripple up/down counter: direction encodings and default width.
package ripple_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int RIPPLE_DEFAULT_WIDTH = 4;

endpackage : ripple_counter_pkg

// File: rtl/ripple_counter_t_flip_flop.sv
// Single counter stage: positive-edge toggle flip-flop with asynchronous active-low clear.
module t_flip_flop (
    input  logic clk,
    input  logic reset,
    input  logic T,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (T) begin
            q <= ~q;
        end
    end

endmodule : t_flip_flop

// File: rtl/ripple_updown_counter.sv
// Binary ripple up/down counter built from a chain of toggle flip-flops.
// Optional terminal-count output `tc` is enabled by defining RIPPLE_TC_EN.
module ripple_updown_counter
    import ripple_counter_pkg::*;
#(
    parameter int WIDTH = RIPPLE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             T,
    input  logic             C,
`ifdef RIPPLE_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] stage_clk;

    assign stage_clk[0] = clk;

    // Up mode clocks a stage on the previous bit falling, down mode on it rising.
    for (genvar i = 1; i < WIDTH; i++) begin : g_stage_clk
        assign stage_clk[i] = Q[i-1] ^ C;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        t_flip_flop u_tff (
            .clk   (stage_clk[i]),
            .reset (reset),
            .T     (T),
            .q     (Q[i])
        );
    end

`ifdef RIPPLE_TC_EN
    // Distinguishes the all-zero reset state from a genuine down-count to zero.
    logic counted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counted <= 1'b0;
        end else if (T) begin
            counted <= 1'b1;
        end
    end

    always_comb begin
        tc = 1'b0;
        if (reset) begin
            if (C == DIR_UP) begin
                tc = &Q;
            end else if (C == DIR_DOWN) begin
                tc = (Q == '0) && counted;
            end
        end
    end
`endif

endmodule : ripple_updown_counter

// File: tb/tb_ripple_updown_counter.sv
// Directed bench for ripple_updown_counter: a 4-bit and a 3-bit instance driven in lockstep.
module tb_ripple_updown_counter;

    logic       clk;
    logic       reset;
    logic       T;
    logic       C;
    logic [3:0] q4;
    logic [2:0] q3;
`ifdef RIPPLE_TC_EN
    logic       tc4;
    logic       tc3;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] exp_q;
    logic       exp_counted;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ripple_updown_counter #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .T     (T),
        .C     (C),
`ifdef RIPPLE_TC_EN
        .tc    (tc4),
`endif
        .Q     (q4)
    );

    ripple_updown_counter #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .T     (T),
        .C     (C),
`ifdef RIPPLE_TC_EN
        .tc    (tc3),
`endif
        .Q     (q3)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compares both instances against the expected 4-bit count (3-bit view is its low bits).
    task automatic check_all(input string tag);
        logic [2:0] e3;
        e3 = exp_q[2:0];
        check({tag, " q4"}, {28'd0, q4}, {28'd0, exp_q});
        check({tag, " q3"}, {29'd0, q3}, {29'd0, e3});
`ifdef RIPPLE_TC_EN
        if (!reset) begin
            check({tag, " tc3"}, {31'd0, tc3}, 32'd0);
        end else if (C) begin
            check({tag, " tc3"}, {31'd0, tc3}, {31'd0, (e3 == 3'd7)});
        end else begin
            check({tag, " tc3"}, {31'd0, tc3}, {31'd0, (e3 == 3'd0) && exp_counted});
        end
`endif
    endtask

    // One rising edge, then settle well clear of it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset       = 1'b0;
        T           = 1'b1;
        C           = 1'b1;
        exp_q       = 4'd0;
        exp_counted = 1'b0;

        // Held in reset while clocking with T=1
        #1;
        check_all("reset_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset_hold");
        end

        // Release between edges, then count up through the wrap and one beyond
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_q       = exp_q + 4'd1;
            exp_counted = 1'b1;
            check_all($sformatf("up_%0d", i + 1));
        end

        // Reach 5, then hold with T=0
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_q = exp_q + 4'd1;
            check_all("up_to5");
        end
        T = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("hold");
        end
        T = 1'b1;
        tick();
        exp_q = exp_q + 4'd1;
        check_all("resume_6");

        // Up to 9, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_q = exp_q + 4'd1;
            check_all("up_to9");
        end
        #1;
        reset       = 1'b0;
        exp_q       = 4'd0;
        exp_counted = 1'b0;
        #1;
        check_all("midcount_reset");
        tick();
        check_all("midcount_reset_held");
        reset = 1'b1;
        tick();
        exp_q       = 4'd1;
        exp_counted = 1'b1;
        check_all("after_release");

        // Down mode: set direction under reset, release, count through zero
        reset       = 1'b0;
        C           = 1'b0;
        exp_q       = 4'd0;
        exp_counted = 1'b0;
        #1;
        check_all("down_reset");
        tick();
        reset = 1'b1;
        #1;
        check_all("down_released");
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_q       = exp_q - 4'd1;
            exp_counted = 1'b1;
            check_all($sformatf("down_%0d", i + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_ripple_updown_counter
